// File: rtl/cpu_pkg.sv
// Shared types and op-class helpers for the Falcon CPU memory stage.
// Opcode values are mirrored here so the memory stage can classify instructions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [5:0] OP_LDB  = 6'h10;
  localparam logic [5:0] OP_LDBU = 6'h11;
  localparam logic [5:0] OP_LDH  = 6'h12;
  localparam logic [5:0] OP_LDHU = 6'h13;
  localparam logic [5:0] OP_LDW  = 6'h14;
  localparam logic [5:0] OP_STB  = 6'h18;
  localparam logic [5:0] OP_STH  = 6'h19;
  localparam logic [5:0] OP_STW  = 6'h1a;
  localparam logic [5:0] OP_CSR  = 6'h30;
  localparam logic [5:0] OP_SYS  = 6'h31;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDW};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_STB, OP_STH, OP_STW};
  endfunction

  // Branches occupy the whole 0x20-0x2f opcode block.
  function automatic logic is_branch(input logic [5:0] op);
    return op[5:4] == 2'b10;
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    return !(is_store(op) || is_branch(op) || op == OP_CSR || op == OP_SYS);
  endfunction

  function automatic logic [1:0] load_size(input logic [5:0] op);
    case (op)
      OP_LDB, OP_LDBU: return SIZE_BYTE;
      OP_LDH, OP_LDHU: return SIZE_HALF;
      default:         return SIZE_WORD;
    endcase
  endfunction

  function automatic logic load_signed(input logic [5:0] op);
    return (op == OP_LDB) || (op == OP_LDH);
  endfunction

endpackage

// File: rtl/cpu_memory_if.sv
// Data-bus handshake between the issuing stage / bus and the memory stage.
interface cpu_memory_if;
  logic        p3_request;
  logic        p3_write;
  logic [1:0]  p3_addr_lsb;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  modport master (output p3_request, p3_write, p3_addr_lsb, cpu_ack, cpu_rdata);
  modport slave  (input  p3_request, p3_write, p3_addr_lsb, cpu_ack, cpu_rdata);
endinterface

// File: rtl/cpu_memory_load_align.sv
// Load data alignment: selects byte/halfword/word by address and extends it.
module cpu_load_align
  import cpu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = rdata[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lanes[addr_lsb];
    half_sel = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
    sign_en  = load_signed(op);
    case (load_size(op))
      SIZE_BYTE: data = {{24{sign_en & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{16{sign_en & half_sel[15]}}, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/cpu_memory.sv
// Falcon CPU stage 4: tracks the data-bus transaction, aligns loads, registers write-back.
// Optional bus timeout is enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_memory
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic [5:0]         p3_op,
  input  logic [4:0]         p3_dest,
  cpu_memory_if.slave        bus,
  input  logic [31:0]        p4_alu_out,
  input  logic [31:0]        p4_mult,
  input  logic               p4_jump_taken,
  output logic               p4_mem_stall,
  output logic [31:0]        p4_result,
  output logic [4:0]         p5_dest,
  output logic [31:0]        p5_wdata,
  output logic               p5_we,
  output logic               p4_bus_error
);

  mem_state_t  state_reg;
  logic [5:0]  p4_op_reg;
  logic [4:0]  p4_dest_reg;
  logic        p4_request_reg;
  logic        p4_write_reg;
  logic [1:0]  p4_lsb_reg;
  logic        p4_valid_reg;
  logic [31:0] hold_data_reg;

  logic        capture;
  logic        new_txn;
  logic        ack_seen;
  logic        timeout;
  logic        wb_en;
  logic [31:0] load_src;
  logic [31:0] load_data;

  assign capture  = !stall;
  assign new_txn  = capture && bus.p3_request && !p4_jump_taken;
  assign ack_seen = (state_reg == WAIT) && bus.cpu_ack;

`ifdef CPU_BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;

  // An ack in the timeout cycle wins, hence the !cpu_ack term.
  assign timeout = (state_reg == WAIT) && !bus.cpu_ack && (tmo_cnt_reg == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if (new_txn) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == WAIT && !bus.cpu_ack) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end
`else
  // Without the timeout the parameter has no effect; this term is constant 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign p4_mem_stall = (state_reg == WAIT) && !bus.cpu_ack && !timeout;
  assign p4_bus_error = timeout;
  assign load_src     = ack_seen ? bus.cpu_rdata : hold_data_reg;

  cpu_load_align u_align (
    .op       (p4_op_reg),
    .addr_lsb (p4_lsb_reg),
    .rdata    (load_src),
    .data     (load_data)
  );

  always_comb begin
    if (is_load(p4_op_reg))      p4_result = load_data;
    else if (p4_op_reg == OP_MUL) p4_result = p4_mult;
    else                          p4_result = p4_alu_out;
  end

  assign wb_en = p4_valid_reg && (p4_dest_reg != 5'd0) && writes_reg(p4_op_reg)
               && !(p4_request_reg && p4_write_reg) && !p4_mem_stall && !timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      p4_op_reg      <= '0;
      p4_dest_reg    <= '0;
      p4_request_reg <= 1'b0;
      p4_write_reg   <= 1'b0;
      p4_lsb_reg     <= '0;
      p4_valid_reg   <= 1'b0;
      hold_data_reg  <= '0;
      p5_dest        <= '0;
      p5_wdata       <= '0;
      p5_we          <= 1'b0;
    end else begin
      if (capture) begin
        p4_op_reg      <= p3_op;
        p4_dest_reg    <= p3_dest;
        p4_request_reg <= bus.p3_request;
        p4_write_reg   <= bus.p3_write;
        p4_lsb_reg     <= bus.p3_addr_lsb;
        p4_valid_reg   <= !p4_jump_taken;
      end else if (timeout) begin
        // An abandoned load must not write back later with stale data.
        p4_valid_reg   <= 1'b0;
      end

      case (state_reg)
        IDLE: if (new_txn) state_reg <= WAIT;
        WAIT: begin
          if (bus.cpu_ack && stall) begin
            state_reg     <= HOLD;
            hold_data_reg <= bus.cpu_rdata;
          end else if (bus.cpu_ack || timeout) begin
            state_reg <= new_txn ? WAIT : IDLE;
          end
        end
        HOLD: if (!stall) state_reg <= new_txn ? WAIT : IDLE;
        default: state_reg <= IDLE;
      endcase

      // A stalled cycle writes a bubble so the held instruction retires once.
      if (stall) begin
        p5_we <= 1'b0;
      end else begin
        p5_dest  <= p4_dest_reg;
        p5_wdata <= p4_result;
        p5_we    <= wb_en;
      end
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// Directed testbench for cpu_memory: loads, stores, held acks, write-back gating, timeout.
module tb_cpu_memory;
  import cpu_pkg::*;

  localparam logic [5:0] OP_ADD = 6'h00;
`ifdef CPU_BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ext_stall = 1'b0;
  logic        stall;
  logic [5:0]  p3_op = OP_ADD;
  logic [4:0]  p3_dest = '0;
  logic [31:0] p4_alu_out = '0;
  logic [31:0] p4_mult = '0;
  logic        p4_jump_taken = 1'b0;
  logic        p4_mem_stall;
  logic [31:0] p4_result;
  logic [4:0]  p5_dest;
  logic [31:0] p5_wdata;
  logic        p5_we;
  logic        p4_bus_error;

  int tests = 0;
  int fails = 0;

  cpu_memory_if bus ();

  cpu_memory #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .p3_op         (p3_op),
    .p3_dest       (p3_dest),
    .bus           (bus),
    .p4_alu_out    (p4_alu_out),
    .p4_mult       (p4_mult),
    .p4_jump_taken (p4_jump_taken),
    .p4_mem_stall  (p4_mem_stall),
    .p4_result     (p4_result),
    .p5_dest       (p5_dest),
    .p5_wdata      (p5_wdata),
    .p5_we         (p5_we),
    .p4_bus_error  (p4_bus_error)
  );

  always #5 clock = ~clock;
  assign stall = ext_stall | p4_mem_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_p3();
    p3_op = OP_ADD; p3_dest = '0;
    bus.p3_request = 1'b0; bus.p3_write = 1'b0; bus.p3_addr_lsb = '0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] dest, input logic wr, input logic [1:0] lsb);
    p3_op = op; p3_dest = dest;
    bus.p3_request = 1'b1; bus.p3_write = wr; bus.p3_addr_lsb = lsb;
  endtask

  // ack_at = 1 acks in the first p4 cycle; returns stall cycles and p5 writes seen.
  task automatic wait_ack(input int ack_at, input logic [31:0] rdata, output int stalls, output int writes);
    stalls = 0; writes = 0;
    for (int i = 1; i <= ack_at; i++) begin
      bus.cpu_ack = (i == ack_at);
      bus.cpu_rdata = (i == ack_at) ? rdata : 32'h0;
      #1;
      stalls += int'(p4_mem_stall);
      tick();
      writes += int'(p5_we);
    end
    bus.cpu_ack = 1'b0;
    bus.cpu_rdata = '0;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  lsb;
    logic [31:0] rdata;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t vecs [4];

  initial begin
    int st, wr;
    bus.cpu_ack = 1'b0; bus.cpu_rdata = '0;
    idle_p3();

    vecs[0] = '{OP_LDB,  2'd2, 32'h1280ff00, 32'hffffff80};
    vecs[1] = '{OP_LDBU, 2'd1, 32'h00009a00, 32'h0000009a};
    vecs[2] = '{OP_LDH,  2'd0, 32'h00008001, 32'hffff8001};
    vecs[3] = '{OP_LDW,  2'd3, 32'hcafe0123, 32'hcafe0123};

    tick(); tick();
    check("rst_p5_we", {31'b0, p5_we}, 32'd0);
    check("rst_p5_dest", {27'b0, p5_dest}, 32'd0);
    check("rst_p5_wdata", p5_wdata, 32'd0);
    check("rst_mem_stall", {31'b0, p4_mem_stall}, 32'd0);
    check("rst_bus_error", {31'b0, p4_bus_error}, 32'd0);
    reset = 1'b0;
    tick();

    // Single-cycle acks across byte/half/word alignments.
    for (int v = 0; v < 4; v++) begin
      issue(vecs[v].op, 5'd3, 1'b0, vecs[v].lsb);
      tick();
      idle_p3();
      wait_ack(1, vecs[v].rdata, st, wr);
      check($sformatf("load%0d_stalls", v), st, 0);
      check($sformatf("load%0d_wdata", v), p5_wdata, vecs[v].exp);
      check($sformatf("load%0d_we", v), {31'b0, p5_we}, 32'd1);
      check($sformatf("load%0d_dest", v), {27'b0, p5_dest}, 32'd3);
      tick();
    end

    // LDHU with the ack three cycles after the request.
    issue(OP_LDHU, 5'd4, 1'b0, 2'd2);
    tick();
    idle_p3();
    wait_ack(3, 32'h80011234, st, wr);
    check("ldhu_stalls", st, 2);
    check("ldhu_wdata", p5_wdata, 32'h00008001);
    check("ldhu_writes", wr, 1);
    tick();

    // Store waits for its ack but never writes the register file.
    issue(OP_STW, 5'd7, 1'b1, 2'd0);
    tick();
    idle_p3();
    wait_ack(2, 32'h0, st, wr);
    check("stw_stalls", st, 1);
    check("stw_writes", wr, 0);
    tick();
    check("stw_we_after", {31'b0, p5_we}, 32'd0);

    // LDW acked under an external stall: latched data retires once.
    issue(OP_LDW, 5'd9, 1'b0, 2'd0);
    tick();
    idle_p3();
    wr = 0;
    ext_stall = 1'b1; bus.cpu_ack = 1'b1; bus.cpu_rdata = 32'hdeadbeef;
    tick(); wr += int'(p5_we);
    bus.cpu_ack = 1'b0; bus.cpu_rdata = 32'h0;
    tick(); wr += int'(p5_we);
    tick(); wr += int'(p5_we);
    ext_stall = 1'b0;
    #1;
    check("hold_result", p4_result, 32'hdeadbeef);
    tick(); wr += int'(p5_we);
    check("hold_wdata", p5_wdata, 32'hdeadbeef);
    check("hold_dest", {27'b0, p5_dest}, 32'd9);
    tick(); wr += int'(p5_we);
    check("hold_writes", wr, 1);

    // ADD to r0 is dropped, MUL to r5 takes the multiplier result.
    p3_op = OP_ADD; p3_dest = 5'd0;
    tick();
    p3_op = OP_MUL; p3_dest = 5'd5; p4_alu_out = 32'h55;
    #1;
    check("add_result", p4_result, 32'h55);
    tick();
    check("add_r0_we", {31'b0, p5_we}, 32'd0);
    idle_p3();
    p4_mult = 32'h30;
    #1;
    check("mul_result", p4_result, 32'h30);
    tick();
    check("mul_wdata", p5_wdata, 32'h30);
    check("mul_we", {31'b0, p5_we}, 32'd1);
    check("mul_dest", {27'b0, p5_dest}, 32'd5);

    // Instruction nullified by a taken jump does not write.
    p3_op = OP_ADD; p3_dest = 5'd6; p4_jump_taken = 1'b1;
    tick();
    p4_jump_taken = 1'b0; idle_p3();
    tick();
    check("jump_null_we", {31'b0, p5_we}, 32'd0);

    // Spurious ack in IDLE neither stalls nor writes.
    bus.cpu_ack = 1'b1;
    #1;
    check("spur_stall", {31'b0, p4_mem_stall}, 32'd0);
    tick();
    bus.cpu_ack = 1'b0;
    check("spur_we", {31'b0, p5_we}, 32'd0);

    // Reset in WAIT abandons the load; a later ack is ignored.
    issue(OP_LDW, 5'd4, 1'b0, 2'd0);
    tick();
    idle_p3();
    #1;
    check("pre_rst_stall", {31'b0, p4_mem_stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.cpu_ack = 1'b1; bus.cpu_rdata = 32'h12345678;
    #1;
    check("post_rst_stall", {31'b0, p4_mem_stall}, 32'd0);
    tick();
    bus.cpu_ack = 1'b0;
    check("post_rst_we", {31'b0, p5_we}, 32'd0);

`ifdef CPU_BUS_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      st = 0;
      issue(OP_LDW, 5'd8, 1'b0, 2'd0);
      tick();
      idle_p3();
      for (int i = 0; i < 12 && !seen; i++) begin
        #1;
        if (p4_bus_error) begin
          seen = 1'b1;
          check("tmo_stall_drop", {31'b0, p4_mem_stall}, 32'd0);
        end else begin
          st += int'(p4_mem_stall);
          tick();
        end
      end
      check("tmo_seen", {31'b0, seen}, 32'd1);
      check("tmo_stalls", st, 4);
      tick();
      check("tmo_we", {31'b0, p5_we}, 32'd0);
      check("tmo_pulse_end", {31'b0, p4_bus_error}, 32'd0);
      bus.cpu_ack = 1'b1; bus.cpu_rdata = 32'hffffffff;
      #1;
      check("tmo_late_stall", {31'b0, p4_mem_stall}, 32'd0);
      tick();
      bus.cpu_ack = 1'b0;
      check("tmo_late_we", {31'b0, p5_we}, 32'd0);
    end
`else
    check("no_tmo_error", {31'b0, p4_bus_error}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
# cpu_memory

Pipeline stage 4 of the Falcon CPU, directly downstream of `cpu_execute`. It tracks the data-bus transaction issued in stage 3 and stalls the pipeline until the bus acknowledges. It aligns and sign- or zero-extends load data, then selects the write-back value from ALU, multiplier or load. The result is registered into stage 5 (dest, data, write-enable) for the register file.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles without `cpu_ack` before a bus timeout is declared. Used only with `CPU_BUS_TIMEOUT_EN`.

Ports (clock and reset first):
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  global pipeline stall; it includes this block's own `p4_mem_stall`
- `p3_op`  in  6  opcode (`OP_*` from `cpu.vh`)
- `p3_dest`  in  5  destination register
- `p3_request`  in  1  bus transaction issued this cycle; already nullified on a taken jump
- `p3_write`  in  1  1 = store
- `p3_addr_lsb`  in  2  `p3_addr[1:0]`
- `p4_alu_out`  in  32  registered ALU result from execute
- `p4_mult`  in  32  registered multiplier result from execute
- `p4_jump_taken`  in  1  nullifies the stage-3 instruction
- `cpu_ack`  in  1  bus completes the transaction; one-cycle pulse
- `cpu_rdata`  in  32  read data, valid with `cpu_ack`
- `p4_mem_stall`  out  1  stage 4 is waiting for the bus
- `p4_result`  out  32  write-back value, also used for forwarding
- `p5_dest`  out  5  registered destination
- `p5_wdata`  out  32  registered write-back data
- `p5_we`  out  1  registered register-file write enable
- `p4_bus_error`  out  1  one-cycle timeout pulse

## Operation
- **Capture.** When `!stall` the block registers `p3_op`, `p3_dest`, `p3_request`, `p3_write` and `p3_addr_lsb` into p4.
  - If `p4_jump_taken` is high, `p4_valid` is captured as 0; otherwise it is 1.
  - When `stall` is high the p4 registers hold their values.
- **State machine.** Three states: IDLE, WAIT, HOLD.
  - IDLE -> WAIT: a transaction is captured into p4.
  - WAIT -> IDLE: `cpu_ack` arrives and `stall` is low.
  - WAIT -> HOLD: `cpu_ack` arrives and `stall` is high. `cpu_rdata` is latched into `hold_data`.
  - HOLD -> IDLE: `stall` falls.
  - WAIT, no ack: stay in WAIT.
  - If a new transaction is captured in the same cycle as a WAIT->IDLE or HOLD->IDLE exit, the next state is WAIT instead.
- **Stall.** `p4_mem_stall = (state==WAIT) && !cpu_ack`. Stores wait for their ack in the same way as loads.
- **Load data.** The source is `cpu_rdata` when acking, otherwise `hold_data`.
  - LDB / LDBU: take byte `addr_lsb` and sign-extend (LDB) or zero-extend (LDBU).
  - LDH / LDHU: take the halfword selected by `addr_lsb[1]` and extend the same way.
  - LDW: take the full word.
- **Result mux.**
  - Load op: the aligned load data.
  - OP_MUL: `p4_mult`.
  - Anything else: `p4_alu_out`.
- **Write-back.** `p5_we` is set when `p4_valid`, `p4_dest != 0`, the op writes a register (stores, branches, CSR/SYS excluded) and `!p4_mem_stall`.
- **Stall bubble.** While `stall` is high, p5 is written with `p5_we = 0`. This prevents a double write.

## Timing
- The earliest `cpu_ack` is one cycle after the `p3_request` cycle, i.e. the first p4 cycle. An ack in that cycle causes zero stall cycles.
- An ack at cycle N+k causes k-1 stall cycles.
- Load data reaches `p5_wdata` on the clock edge at which the ack is seen and `stall` is low.
- `cpu_ack` seen in IDLE is spurious and ignored.
- Reset values:
  - state: IDLE
  - `p4_valid`: 0
  - `p4_mem_stall`: 0
  - `p5_we`: 0
  - `p5_dest`: 0
  - `p5_wdata`: 0
  - `p4_bus_error`: 0
  - timeout counter: 0
- Reset during WAIT abandons the transaction. A later ack is ignored.

## Configuration
- `CPU_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering WAIT and increments each WAIT cycle without an ack.
  - When it reaches `TIMEOUT_CYCLES`, the block pulses `p4_bus_error`, drops `p4_mem_stall`, forces `p5_we` to 0 and goes to IDLE.
  - An ack in the same cycle as the timeout wins.
- Not defined: no counter, `p4_bus_error` is tied to 0, and WAIT is unbounded.

## Structure
- `cpu_pkg` holds:
  - the `mem_state_t` enum (IDLE/WAIT/HOLD)
  - the size encodings (00 byte, 01 half, 10 word)
  - the `is_load` / `writes_reg` op-class functions
- Opcodes stay in `cpu.vh`.
- One combinational sub-module, `cpu_load_align` (op, addr_lsb, rdata -> data), is natural.

## Test plan
- LDB at lsb=2, ack in the first p4 cycle, rdata=0x1280FF00 -> no stall; `p5_wdata`=0xFFFFFF80; `p5_we`=1.
- LDHU at lsb=2, ack after 3 cycles, rdata=0x8001_1234 -> `p4_mem_stall` high for 2 cycles; `p5_wdata`=0x00008001.
- STW with ack delayed 2 cycles -> stalls 1 cycle; `p5_we`=0 throughout.
- LDW acked while an external `stall` is held for 3 cycles -> HOLD state; after release `p5_wdata` equals the latched rdata and is written exactly once.
- ADD to r0, then MUL to r5 with `p4_mult`=0x30 -> first gives `p5_we`=0; second gives `p5_wdata`=0x30, `p5_we`=1.
- With `CPU_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4 and no ack -> `p4_bus_error` pulses 4 cycles into WAIT, the stall drops, no write; a late ack is ignored.
